// File: rtl/game_pkg.sv
// Shared types and widths for the escape-room game phase controller.
// State encoding is fixed because it is exported on the state port.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2,
      ST_OVER  = 2'd3
   } game_state_e;

   localparam int STAB_W = 4;
   localparam int TIME_W = 13;
   localparam int PIDX_W = 3;
   localparam int HOLD_W = 8;

   typedef logic [STAB_W-1:0] stab_t;
   typedef logic [TIME_W-1:0] time_t;

   function automatic time_t time_sat_sub(input time_t t, input time_t d);
      return (t > d) ? (t - d) : '0;
   endfunction

endpackage

// File: rtl/game_phase_controller_if.sv
// Random-event handshake bundle: requesters on the master side,
// the event arbiter on the slave side.
interface game_phase_controller_if #(
   parameter int NUM_EVENTS = 2
);
   logic [NUM_EVENTS-1:0] ev_req;
   logic [NUM_EVENTS-1:0] ev_done_ok;
   logic [NUM_EVENTS-1:0] ev_done_fail;
   logic [NUM_EVENTS-1:0] ev_grant;
   logic                  ev_busy;

   modport master (
      output ev_req, ev_done_ok, ev_done_fail,
      input  ev_grant, ev_busy
   );

   modport slave (
      input  ev_req, ev_done_ok, ev_done_fail,
      output ev_grant, ev_busy
   );
endinterface

// File: rtl/event_arbiter.sv
// Random-event arbiter: lowest-index priority grant, busy tracking of the
// granted channel, and a tick-based holdoff between consecutive events.
module event_arbiter
   import game_pkg::*;
#(
   parameter int NUM_EVENTS = 2,
   parameter int EV_HOLDOFF = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic                    hold_clr,
   input  logic                    tick,
   game_phase_controller_if.slave  ev,
   output logic                    ok_hit,
   output logic                    fail_hit
);

   localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(EV_HOLDOFF);

   logic                  busy_q, busy_d;
   logic [NUM_EVENTS-1:0] grant_q, grant_d;
   logic [NUM_EVENTS-1:0] gnt_oh_q, gnt_oh_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [NUM_EVENTS-1:0] pick;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_pick
         if (gi == 0) begin : g_first
            assign pick[gi] = ev.ev_req[gi];
         end else begin : g_rest
            assign pick[gi] = ev.ev_req[gi] & ~(|ev.ev_req[gi-1:0]);
         end
      end
   endgenerate

   // Only the done pulses of the channel we granted are honoured.
   assign ok_hit   = busy_q & (|(ev.ev_done_ok   & gnt_oh_q));
   assign fail_hit = busy_q & (|(ev.ev_done_fail & gnt_oh_q));

   assign ev.ev_grant = grant_q;
   assign ev.ev_busy  = busy_q;

   always_comb begin
      busy_d     = busy_q;
      grant_d    = '0;
      gnt_oh_d   = gnt_oh_q;
      hold_cnt_d = hold_cnt_q;
      if (hold_clr) begin
         hold_cnt_d = '0;
         busy_d     = 1'b0;
      end else if (!run) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         if (ok_hit || fail_hit) begin
            busy_d     = 1'b0;
            hold_cnt_d = '0;
         end
      end else if (hold_cnt_q >= HOLD_TOP) begin
         if (|pick) begin
            grant_d  = pick;
            gnt_oh_d = pick;
            busy_d   = 1'b1;
         end
      end else if (tick) begin
         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         grant_q    <= '0;
         gnt_oh_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         gnt_oh_q   <= gnt_oh_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

endmodule

// File: rtl/game_phase_controller.sv
// Game phase controller: sequences puzzle phases, tracks stability and the
// countdown, and hands random events to the event arbiter.
module game_phase_controller
   import game_pkg::*;
#(
   parameter int NUM_PHASES = 4,
   parameter int NUM_EVENTS = 2,
   parameter int STAB_MAX   = 9,
   parameter int TIME_INIT  = 300,
   parameter int EV_HOLDOFF = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_btn,
   input  logic                  tick_1hz,
   input  logic [NUM_PHASES-1:0] phase_clear,
   input  logic [NUM_PHASES-1:0] phase_fail,
   input  logic [NUM_PHASES-1:0] phase_correct,
   input  logic [NUM_EVENTS-1:0] ev_req,
   input  logic [NUM_EVENTS-1:0] ev_done_ok,
   input  logic [NUM_EVENTS-1:0] ev_done_fail,
   output logic [1:0]            state,
   output logic [2:0]            phase_idx,
   output logic [NUM_PHASES-1:0] phase_en,
   output logic [NUM_EVENTS-1:0] ev_grant,
   output logic                  ev_busy,
   output logic [3:0]            stability,
   output logic [12:0]           time_left,
   output logic                  game_clear,
   output logic                  game_over
);

   localparam stab_t             STAB_TOP = stab_t'(STAB_MAX);
   localparam time_t             TIME_TOP = time_t'(TIME_INIT);
   localparam logic [PIDX_W-1:0] LAST_IDX = PIDX_W'(NUM_PHASES - 1);

   game_state_e         state_q, state_d;
   logic [PIDX_W-1:0]   phase_idx_q, phase_idx_d;
   stab_t               stab_q, stab_d;
   time_t               time_q, time_d;
   logic                game_clear_q, game_clear_d;
   logic                game_over_q, game_over_d;

   logic [NUM_PHASES-1:0] phase_oh;
   logic                  p_clr, p_fail, p_corr;
   logic                  fail_any, succ_any;
   logic                  hold_clr, run_keep;
   logic                  ev_ok_hit, ev_fail_hit;
   time_t                 time_dec;

   game_phase_controller_if #(.NUM_EVENTS(NUM_EVENTS)) ev_bus ();

   assign ev_bus.ev_req       = ev_req;
   assign ev_bus.ev_done_ok   = ev_done_ok;
   assign ev_bus.ev_done_fail = ev_done_fail;
   assign ev_grant            = ev_bus.ev_grant;
   assign ev_busy             = ev_bus.ev_busy;

   // Arbiter only sees RUN while the game is staying in RUN, so busy drops
   // on the same edge that leaves RUN.
   assign run_keep = (state_q == ST_RUN) && (state_d == ST_RUN);

   event_arbiter #(
      .NUM_EVENTS (NUM_EVENTS),
      .EV_HOLDOFF (EV_HOLDOFF)
   ) u_event_arbiter (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run_keep),
      .hold_clr (hold_clr),
      .tick     (tick_1hz),
      .ev       (ev_bus.slave),
      .ok_hit   (ev_ok_hit),
      .fail_hit (ev_fail_hit)
   );

   assign phase_oh = NUM_PHASES'(1) << phase_idx_q;
   assign p_clr    = |(phase_clear   & phase_oh);
   assign p_fail   = |(phase_fail    & phase_oh);
   assign p_corr   = |(phase_correct & phase_oh);
   assign fail_any = p_fail | ev_fail_hit;
   assign succ_any = p_corr | ev_ok_hit;
   assign time_dec = (stab_q <= stab_t'(2)) ? time_t'(2) : time_t'(1);

   always_comb begin
      state_d      = state_q;
      phase_idx_d  = phase_idx_q;
      stab_d       = stab_q;
      time_d       = time_q;
      game_clear_d = 1'b0;
      game_over_d  = 1'b0;
      hold_clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_btn) begin
               state_d     = ST_RUN;
               phase_idx_d = '0;
               stab_d      = STAB_TOP;
               time_d      = TIME_TOP;
               hold_clr    = 1'b1;
            end
         end
         ST_RUN: begin
            // A clear on the final phase wins over everything else that cycle.
            if (p_clr && (phase_idx_q == LAST_IDX)) begin
               state_d      = ST_CLEAR;
               game_clear_d = 1'b1;
            end else begin
               if (p_clr) begin
                  phase_idx_d = phase_idx_q + PIDX_W'(1);
               end
               if (fail_any) begin
                  if (stab_q != '0) begin
                     stab_d = stab_q - stab_t'(1);
                  end
               end else if (succ_any && (stab_q < STAB_TOP)) begin
                  stab_d = stab_q + stab_t'(1);
               end
               if (tick_1hz) begin
                  time_d = time_sat_sub(time_q, time_dec);
               end
               if (!p_clr && ((stab_d == '0) || (time_d == '0))) begin
                  state_d     = ST_OVER;
                  game_over_d = 1'b1;
               end
            end
         end
         default: begin
            if (start_btn) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_idx_q  <= '0;
         stab_q       <= STAB_TOP;
         time_q       <= TIME_TOP;
         game_clear_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_idx_q  <= phase_idx_d;
         stab_q       <= stab_d;
         time_q       <= time_d;
         game_clear_q <= game_clear_d;
         game_over_q  <= game_over_d;
      end
   end

   assign state      = state_q;
   assign phase_idx  = phase_idx_q;
   assign phase_en   = (state_q == ST_RUN) ? phase_oh : '0;
   assign stability  = stab_q;
   assign time_left  = time_q;
   assign game_clear = game_clear_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_phase_controller.sv
// Directed bench for game_phase_controller: default-parameter instance plus a
// TIME_INIT=5 instance sharing the same stimulus.
module tb_game_phase_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_btn;
   logic       tick_1hz;
   logic [3:0] phase_clear, phase_fail, phase_correct;

   logic [1:0]  state, state2;
   logic [2:0]  phase_idx, phase_idx2;
   logic [3:0]  phase_en, phase_en2;
   logic [1:0]  ev_grant2;
   logic        ev_busy2;
   logic [3:0]  stability, stability2;
   logic [12:0] time_left, time_left2;
   logic        game_clear, game_clear2;
   logic        game_over, game_over2;

   int n_checks = 0;
   int n_errors = 0;

   game_phase_controller_if #(.NUM_EVENTS(2)) ev_if ();

   always #5 clk = ~clk;

   game_phase_controller u_dut (
      .clk (clk), .rst_n (rst_n), .start_btn (start_btn), .tick_1hz (tick_1hz),
      .phase_clear (phase_clear), .phase_fail (phase_fail), .phase_correct (phase_correct),
      .ev_req (ev_if.ev_req), .ev_done_ok (ev_if.ev_done_ok), .ev_done_fail (ev_if.ev_done_fail),
      .state (state), .phase_idx (phase_idx), .phase_en (phase_en),
      .ev_grant (ev_if.ev_grant), .ev_busy (ev_if.ev_busy),
      .stability (stability), .time_left (time_left),
      .game_clear (game_clear), .game_over (game_over)
   );

   game_phase_controller #(.TIME_INIT(5)) u_dut_t5 (
      .clk (clk), .rst_n (rst_n), .start_btn (start_btn), .tick_1hz (tick_1hz),
      .phase_clear (phase_clear), .phase_fail (phase_fail), .phase_correct (phase_correct),
      .ev_req (ev_if.ev_req), .ev_done_ok (ev_if.ev_done_ok), .ev_done_fail (ev_if.ev_done_fail),
      .state (state2), .phase_idx (phase_idx2), .phase_en (phase_en2),
      .ev_grant (ev_grant2), .ev_busy (ev_busy2),
      .stability (stability2), .time_left (time_left2),
      .game_clear (game_clear2), .game_over (game_over2)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
   endtask

   task automatic tick();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
   endtask

   int seen;

   initial begin
      rst_n = 1'b0; start_btn = 1'b0; tick_1hz = 1'b0;
      phase_clear = '0; phase_fail = '0; phase_correct = '0;
      ev_if.ev_req = '0; ev_if.ev_done_ok = '0; ev_if.ev_done_fail = '0;
      #12;
      check("rst_state", state, 0);
      check("rst_phase_en", phase_en, 0);
      check("rst_busy", ev_if.ev_busy, 0);
      check("rst_stab", stability, 9);
      check("rst_time", time_left, 300);
      check("rst_over", game_over, 0);
      rst_n = 1'b1;
      cyc();

      // Four clears walk the one-hot enable and end in CLEAR.
      press_start();
      check("a_state_run", state, 1);
      check("a_stab", stability, 9);
      phase_clear = 4'b1000;
      cyc();
      phase_clear = '0;
      check("a_ignore_other_bit", phase_idx, 0);
      for (int i = 0; i < 4; i++) begin
         check("a_phase_en", phase_en, 1 << i);
         check("a_clear_low", game_clear, 0);
         phase_clear = 4'(1 << i);
         cyc();
         phase_clear = '0;
      end
      check("a_state_clear", state, 2);
      check("a_clear_pulse", game_clear, 1);
      check("a_en_zero", phase_en, 0);
      cyc();
      check("a_clear_once", game_clear, 0);
      press_start();
      check("a_back_idle", state, 0);

      // Nine fails drain stability; time then stays frozen.
      press_start();
      tick();
      check("b_time", time_left, 299);
      phase_fail = 4'b0001;
      repeat (8) cyc();
      check("b_stab1", stability, 1);
      check("b_still_run", state, 1);
      cyc();
      phase_fail = '0;
      check("b_stab0", stability, 0);
      check("b_state_over", state, 3);
      check("b_over_pulse", game_over, 1);
      tick();
      check("b_over_once", game_over, 0);
      tick();
      check("b_time_frozen", time_left, 299);
      press_start();
      check("b_back_idle", state, 0);

      // Saturation, fail-beats-success, and last-phase clear with fail.
      press_start();
      phase_correct = 4'b0001;
      cyc();
      check("c_stab_sat", stability, 9);
      phase_correct = '0;
      phase_fail = 4'b0001;
      repeat (4) cyc();
      check("c_stab5", stability, 5);
      phase_correct = 4'b0001;
      cyc();
      check("c_fail_wins", stability, 4);
      phase_fail = '0;
      cyc();
      check("c_correct_inc", stability, 5);
      phase_correct = 4'b0010;
      cyc();
      phase_correct = '0;
      check("c_correct_other", stability, 5);
      for (int i = 0; i < 3; i++) begin
         phase_clear = 4'(1 << i);
         cyc();
      end
      phase_clear = 4'b1000;
      phase_fail  = 4'b1000;
      cyc();
      phase_clear = '0;
      phase_fail  = '0;
      check("c_last_clear", state, 2);
      check("c_last_stab", stability, 5);
      press_start();

      // Event arbitration with holdoff.
      ev_if.ev_req = 2'b11;
      press_start();
      check("d_no_grant_start", ev_if.ev_grant, 0);
      tick();
      tick();
      cyc();
      check("d_holdoff_grant", ev_if.ev_grant, 0);
      tick();
      check("d_grant_latency", ev_if.ev_grant, 0);
      cyc();
      check("d_grant", ev_if.ev_grant, 1);
      check("d_busy", ev_if.ev_busy, 1);
      cyc();
      check("d_grant_one_cycle", ev_if.ev_grant, 0);
      ev_if.ev_done_fail = 2'b10;
      cyc();
      ev_if.ev_done_fail = '0;
      check("d_other_fail_busy", ev_if.ev_busy, 1);
      check("d_other_fail_stab", stability, 9);
      ev_if.ev_done_ok = 2'b01;
      cyc();
      ev_if.ev_done_ok = '0;
      check("d_ok_clears", ev_if.ev_busy, 0);
      seen = 0;
      repeat (3) begin
         cyc();
         seen = seen | int'(ev_if.ev_grant);
      end
      tick();
      seen = seen | int'(ev_if.ev_grant);
      tick();
      seen = seen | int'(ev_if.ev_grant);
      cyc();
      seen = seen | int'(ev_if.ev_grant);
      check("d_holdoff2", seen, 0);
      tick();
      cyc();
      check("d_regrant", ev_if.ev_grant, 1);
      ev_if.ev_done_fail = 2'b01;
      cyc();
      ev_if.ev_done_fail = '0;
      check("d_ev_fail_busy", ev_if.ev_busy, 0);
      check("d_ev_fail_stab", stability, 8);
      tick(); tick(); tick();
      cyc();
      check("d_third_grant", ev_if.ev_grant, 1);
      check("d_time", time_left, 291);

      // Asynchronous reset while an event is active.
      #2;
      rst_n = 1'b0;
      #1;
      check("e_state", state, 0);
      check("e_busy", ev_if.ev_busy, 0);
      check("e_grant", ev_if.ev_grant, 0);
      check("e_stab", stability, 9);
      check("e_time", time_left, 300);
      check("e_phase_en", phase_en, 0);
      #3;
      rst_n = 1'b1;
      cyc();
      seen = 0;
      repeat (4) begin
         tick();
         seen = seen | int'(ev_if.ev_grant) | int'(ev_if.ev_busy);
         cyc();
         seen = seen | int'(ev_if.ev_grant) | int'(ev_if.ev_busy);
      end
      check("e_no_grant", seen, 0);
      check("e_idle", state, 0);
      ev_if.ev_req = '0;

      // Low stability doubles the countdown rate (TIME_INIT=5 instance).
      press_start();
      phase_fail = 4'b0001;
      repeat (7) cyc();
      phase_fail = '0;
      check("f_stab2", stability2, 2);
      check("f_time5", time_left2, 5);
      tick();
      check("f_time3", time_left2, 3);
      tick();
      check("f_time1", time_left2, 1);
      check("f_run", state2, 1);
      tick();
      check("f_time0", time_left2, 0);
      check("f_over", state2, 3);
      check("f_over_pulse", game_over2, 1);
      check("f_main_time", time_left, 294);
      cyc();
      check("f_over_once", game_over2, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
